// File: rtl/ifu_pkg.sv
// Shared widths, reset address and queue entry layout for the instruction-fetch queue.
package ifu_pkg;

  localparam int XLEN        = 64;
  localparam int INSTR_W     = 32;
  localparam int INSTR_BYTES = 4;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 64'h8000_0000;

  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  localparam int ENTRY_W = $bits(fetch_entry_t);

  // Sequential fetch address; wraps at 2^64 with the carry discarded.
  function automatic logic [XLEN-1:0] next_fetch_pc(input logic [XLEN-1:0] pc);
    return pc + XLEN'(INSTR_BYTES);
  endfunction

endpackage

// File: rtl/ifu_fetch_queue_if.sv
// Fetch-side and decode-side handshake bundle of the fetch queue.
interface ifu_fetch_queue_if;
  import ifu_pkg::*;

  logic [XLEN-1:0]    fetch_pc;
  logic               fetch_en;
  logic               req_fire;
  logic [INSTR_W-1:0] in_instr;
  logic               in_valid;

  logic               out_valid;
  logic               out_ready;
  logic [INSTR_W-1:0] out_instr;
  logic [XLEN-1:0]    out_pc;

  modport master (
    input  fetch_pc, fetch_en, out_valid, out_instr, out_pc,
    output req_fire, in_instr, in_valid, out_ready
  );

  modport slave (
    output fetch_pc, fetch_en, out_valid, out_instr, out_pc,
    input  req_fire, in_instr, in_valid, out_ready
  );
endinterface

// File: rtl/ifu_sync_fifo.sv
// Generic synchronous FIFO with flush; head data reads as zero while empty.
module ifu_sync_fifo #(
  parameter int WIDTH = 96,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign full     = (count == (AW+1)'(DEPTH));
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Flush wins over any push or pop in the same cycle.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ifu_fetch_queue.sv
// Owns the fetch PC, tags returned instructions with their address and queues them
// toward decode; redirects flush the queue and drop the stale in-flight response.
module ifu_fetch_queue
  import ifu_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst,
  ifu_fetch_queue_if.slave          bus,
  input  logic                      redirect_valid,
  input  logic [XLEN-1:0]           redirect_pc,
  output logic [$clog2(DEPTH):0]    occupancy,
  output logic                      err_spurious
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [XLEN-1:0] fetch_pc_q;
  logic [XLEN-1:0] inflight_pc;
  logic            outstanding;
  logic            drop;
  logic            push;
  logic            pop;
  logic            fifo_full;
  logic            fifo_empty;
  logic [CW:0]     reserved;
  fetch_entry_t    push_entry;
  fetch_entry_t    head_entry;

  // Every in-flight request holds a queue slot, so a response always has room.
  assign reserved     = {1'b0, occupancy} + {{CW{1'b0}}, outstanding};
  assign bus.fetch_en = !redirect_valid && (reserved < (CW+1)'(DEPTH));
  assign bus.fetch_pc = fetch_pc_q;

  assign push = bus.in_valid && outstanding && !drop && !redirect_valid && !fifo_full;
  assign pop  = bus.out_valid && bus.out_ready && !redirect_valid;

  assign push_entry.pc    = inflight_pc;
  assign push_entry.instr = bus.in_instr;

  ifu_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .pop_data  (head_entry),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (occupancy)
  );

  assign bus.out_valid = !fifo_empty;
  assign bus.out_instr = head_entry.instr;
  assign bus.out_pc    = head_entry.pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q   <= RESET_PC;
      inflight_pc  <= '0;
      outstanding  <= 1'b0;
      drop         <= 1'b0;
      err_spurious <= 1'b0;
    end else begin
      if (redirect_valid) begin
        fetch_pc_q <= redirect_pc;
      end else if (bus.req_fire) begin
        fetch_pc_q <= next_fetch_pc(fetch_pc_q);
      end

      if (bus.req_fire) begin
        inflight_pc <= fetch_pc_q;
      end

      // A response retires the previous request; a new request in the same cycle re-arms.
      if (bus.req_fire) begin
        outstanding <= 1'b1;
      end else if (bus.in_valid && outstanding) begin
        outstanding <= 1'b0;
      end

      if (redirect_valid) begin
        drop <= (outstanding && !bus.in_valid) || bus.req_fire;
      end else if (drop && bus.in_valid) begin
        drop <= 1'b0;
      end

      if (bus.in_valid && !outstanding) begin
        err_spurious <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ifu_fetch_queue.sv
// Directed self-checking bench for ifu_fetch_queue with hand-computed expectations.
module tb_ifu_fetch_queue;
  import ifu_pkg::*;

  localparam logic [63:0] RST_PC = 64'h8000_0000;

  logic        clk;
  logic        rst;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic [2:0]  occupancy;
  logic        err_spurious;
  int          checks;
  int          errors;

  ifu_fetch_queue_if bus();

  ifu_fetch_queue #(
    .DEPTH    (4),
    .RESET_PC (RST_PC)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus.slave),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .occupancy      (occupancy),
    .err_spurious   (err_spurious)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic req, input logic iv, input logic [31:0] instr);
    bus.req_fire = req;
    bus.in_valid = iv;
    bus.in_instr = instr;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    bus.out_ready = 1'b0;
    drive(1'b0, 1'b0, 32'h0);
    tick();
    tick();
    checks++;
    if (bus.fetch_pc !== RST_PC) begin
      errors++; $display("[TB] FAIL reset_fetch_pc got %h exp %h", bus.fetch_pc, RST_PC);
    end
    checks++;
    if (occupancy !== 3'd0 || bus.out_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_empty got occ %0d valid %b exp 0 0", occupancy, bus.out_valid);
    end
    checks++;
    if (bus.out_pc !== 64'h0 || bus.out_instr !== 32'h0) begin
      errors++; $display("[TB] FAIL reset_head got %h %h exp 0 0", bus.out_pc, bus.out_instr);
    end
    checks++;
    if (err_spurious !== 1'b0 || bus.fetch_en !== 1'b1) begin
      errors++; $display("[TB] FAIL reset_flags got err %b en %b exp 0 1", err_spurious, bus.fetch_en);
    end
    rst = 1'b0;
  endtask

  task automatic test_stream();
    logic [31:0] instrs [3];
    logic [63:0] pcs [3];
    instrs = '{32'h0000_0013, 32'h0010_0093, 32'h0020_0113};
    pcs    = '{64'h8000_0000, 64'h8000_0004, 64'h8000_0008};
    bus.out_ready = 1'b1;
    drive(1'b1, 1'b0, 32'h0);
    tick();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.fetch_pc !== 64'h8000_0004) begin
      errors++; $display("[TB] FAIL stream_first_req got valid %b pc %h exp 0 80000004", bus.out_valid, bus.fetch_pc);
    end
    for (int i = 0; i < 3; i++) begin
      drive((i < 2) ? 1'b1 : 1'b0, 1'b1, instrs[i]);
      tick();
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_pc !== pcs[i] || bus.out_instr !== instrs[i]) begin
        errors++;
        $display("[TB] FAIL stream_entry%0d got v %b pc %h instr %h exp 1 %h %h",
                 i, bus.out_valid, bus.out_pc, bus.out_instr, pcs[i], instrs[i]);
      end
    end
    drive(1'b0, 1'b0, 32'h0);
    tick();
    checks++;
    if (occupancy !== 3'd0 || bus.out_valid !== 1'b0 || bus.fetch_pc !== 64'h8000_000C) begin
      errors++; $display("[TB] FAIL stream_drained got occ %0d v %b pc %h exp 0 0 8000000c",
                         occupancy, bus.out_valid, bus.fetch_pc);
    end
  endtask

  task automatic test_backpressure();
    logic        req_v [6];
    logic        iv_v [6];
    logic [31:0] instr_v [6];
    logic        exp_en [6];
    logic [2:0]  exp_occ [6];
    logic [63:0] drain_pc [4];
    req_v    = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    iv_v     = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    instr_v  = '{32'h0, 32'h0030_0193, 32'h0040_0213, 32'h0050_0293, 32'h0060_0313, 32'h0};
    exp_en   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    exp_occ  = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
    drain_pc = '{64'h8000_000C, 64'h8000_0010, 64'h8000_0014, 64'h8000_0018};
    bus.out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive(req_v[i], iv_v[i], instr_v[i]);
      #1;
      checks++;
      if (bus.fetch_en !== exp_en[i]) begin
        errors++; $display("[TB] FAIL bp_fetch_en%0d got %b exp %b", i, bus.fetch_en, exp_en[i]);
      end
      tick();
      checks++;
      if (occupancy !== exp_occ[i]) begin
        errors++; $display("[TB] FAIL bp_occ%0d got %0d exp %0d", i, occupancy, exp_occ[i]);
      end
    end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bus.out_pc !== drain_pc[i] || bus.out_instr !== instr_v[i+1] || occupancy !== 3'(4 - i)) begin
        errors++;
        $display("[TB] FAIL bp_drain%0d got pc %h instr %h occ %0d exp %h %h %0d",
                 i, bus.out_pc, bus.out_instr, occupancy, drain_pc[i], instr_v[i+1], 4 - i);
      end
      tick();
    end
    checks++;
    if (occupancy !== 3'd0 || bus.out_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL bp_empty got occ %0d v %b exp 0 0", occupancy, bus.out_valid);
    end
  endtask

  task automatic test_redirect_outstanding();
    bus.out_ready = 1'b0;
    drive(1'b1, 1'b0, 32'h0);
    tick();
    drive(1'b1, 1'b1, 32'h0000_1111);
    tick();
    drive(1'b1, 1'b1, 32'h0000_2222);
    tick();
    checks++;
    if (occupancy !== 3'd2 || bus.fetch_pc !== 64'h8000_0028) begin
      errors++; $display("[TB] FAIL rd_setup got occ %0d pc %h exp 2 80000028", occupancy, bus.fetch_pc);
    end
    drive(1'b0, 1'b0, 32'h0);
    redirect_valid = 1'b1;
    redirect_pc = 64'h8000_0100;
    bus.out_ready = 1'b1;
    #1;
    checks++;
    if (bus.fetch_en !== 1'b0) begin
      errors++; $display("[TB] FAIL rd_fetch_en got %b exp 0", bus.fetch_en);
    end
    tick();
    redirect_valid = 1'b0;
    checks++;
    if (occupancy !== 3'd0 || bus.out_valid !== 1'b0 || bus.fetch_pc !== 64'h8000_0100) begin
      errors++; $display("[TB] FAIL rd_flush got occ %0d v %b pc %h exp 0 0 80000100",
                         occupancy, bus.out_valid, bus.fetch_pc);
    end
    drive(1'b1, 1'b1, 32'hDEAD_BEEF);
    tick();
    checks++;
    if (occupancy !== 3'd0 || bus.out_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL rd_stale_dropped got occ %0d v %b exp 0 0", occupancy, bus.out_valid);
    end
    drive(1'b0, 1'b1, 32'h0070_0393);
    bus.out_ready = 1'b0;
    tick();
    checks++;
    if (bus.out_pc !== 64'h8000_0100 || bus.out_instr !== 32'h0070_0393 || occupancy !== 3'd1) begin
      errors++; $display("[TB] FAIL rd_new_entry got pc %h instr %h occ %0d exp 80000100 00700393 1",
                         bus.out_pc, bus.out_instr, occupancy);
    end
    drive(1'b0, 1'b0, 32'h0);
    bus.out_ready = 1'b1;
    tick();
    checks++;
    if (occupancy !== 3'd0 || err_spurious !== 1'b0) begin
      errors++; $display("[TB] FAIL rd_drain got occ %0d err %b exp 0 0", occupancy, err_spurious);
    end
  endtask

  task automatic test_redirect_same_cycle();
    bus.out_ready = 1'b0;
    drive(1'b1, 1'b0, 32'h0);
    tick();
    drive(1'b0, 1'b1, 32'h1111_1111);
    redirect_valid = 1'b1;
    redirect_pc = 64'h8000_0200;
    tick();
    redirect_valid = 1'b0;
    drive(1'b0, 1'b0, 32'h0);
    #1;
    checks++;
    if (occupancy !== 3'd0 || bus.fetch_pc !== 64'h8000_0200 || bus.fetch_en !== 1'b1) begin
      errors++; $display("[TB] FAIL rs_flush got occ %0d pc %h en %b exp 0 80000200 1",
                         occupancy, bus.fetch_pc, bus.fetch_en);
    end
    drive(1'b1, 1'b0, 32'h0);
    tick();
    drive(1'b0, 1'b1, 32'h0080_0413);
    tick();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_pc !== 64'h8000_0200 || bus.out_instr !== 32'h0080_0413) begin
      errors++; $display("[TB] FAIL rs_next_pushed got v %b pc %h instr %h exp 1 80000200 00800413",
                         bus.out_valid, bus.out_pc, bus.out_instr);
    end
    drive(1'b0, 1'b0, 32'h0);
    bus.out_ready = 1'b1;
    tick();
  endtask

  task automatic test_spurious();
    drive(1'b0, 1'b1, 32'h2222_2222);
    tick();
    drive(1'b0, 1'b0, 32'h0);
    checks++;
    if (occupancy !== 3'd0 || err_spurious !== 1'b1) begin
      errors++; $display("[TB] FAIL spurious_flag got occ %0d err %b exp 0 1", occupancy, err_spurious);
    end
    tick();
    tick();
    checks++;
    if (err_spurious !== 1'b1) begin
      errors++; $display("[TB] FAIL spurious_sticky got %b exp 1", err_spurious);
    end
  endtask

  task automatic test_reset_midstream();
    bus.out_ready = 1'b0;
    drive(1'b1, 1'b0, 32'h0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 32'h0000_0100 + 32'(i));
      tick();
    end
    checks++;
    if (occupancy !== 3'd3) begin
      errors++; $display("[TB] FAIL rm_setup got occ %0d exp 3", occupancy);
    end
    drive(1'b0, 1'b0, 32'h0);
    rst = 1'b1;
    tick();
    checks++;
    if (occupancy !== 3'd0 || bus.out_valid !== 1'b0 || bus.fetch_pc !== RST_PC || bus.fetch_en !== 1'b1) begin
      errors++; $display("[TB] FAIL rm_state got occ %0d v %b pc %h en %b exp 0 0 80000000 1",
                         occupancy, bus.out_valid, bus.fetch_pc, bus.fetch_en);
    end
    checks++;
    if (err_spurious !== 1'b0) begin
      errors++; $display("[TB] FAIL rm_err_cleared got %b exp 0", err_spurious);
    end
    rst = 1'b0;
    drive(1'b1, 1'b0, 32'h0);
    tick();
    drive(1'b0, 1'b1, 32'h0090_0493);
    tick();
    drive(1'b0, 1'b0, 32'h0);
    checks++;
    if (bus.out_pc !== RST_PC || bus.out_instr !== 32'h0090_0493 || occupancy !== 3'd1) begin
      errors++; $display("[TB] FAIL rm_refetch got pc %h instr %h occ %0d exp 80000000 00900493 1",
                         bus.out_pc, bus.out_instr, occupancy);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_outstanding();
    test_redirect_same_cycle();
    test_spurious();
    test_reset_midstream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL timeout got running exp finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule
